// File: rtl/clock_step_sequencer_pkg.sv
// ============================================================================
// Module      : clock_seq_defs (package)
// Description : Shared state encodings and default constants for the core
//               clock step sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_seq_defs;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2,
    RUN    = 2'd3
  } seq_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES   = 1_000_000;
  localparam int DEFAULT_FAST_DIV          = 2;
  localparam int DEFAULT_SLOW_DIV          = 10_000_000;
  localparam int DEFAULT_RESET_HOLD_CYCLES = 16;

  // Sized for the slowest supported run rate.
  localparam int DIV_W = $clog2(DEFAULT_SLOW_DIV);

endpackage

`default_nettype wire

// File: rtl/clock_step_sequencer_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : Synchronizes a raw active-low button, accepts a level after a
//               run of equal samples, and pulses once per accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer
  import clock_seq_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock_100mhz,
  input  logic reset_button,
  input  logic button_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             press_q;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_100mhz or negedge reset_button) begin
    if (!reset_button) begin
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], button_i};
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      // Pulse only on an accepted released-to-pressed transition.
      press_q     <= level_dly_q & ~level_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/clock_step_sequencer.sv
// ============================================================================
// Module      : clock_step_sequencer
// Description : Run/halt/single-step sequencer producing a one-cycle core clock
//               enable, a held core reset and a retired-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_step_sequencer
  import clock_seq_defs::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FAST_DIV          = DEFAULT_FAST_DIV,
  parameter int SLOW_DIV          = DEFAULT_SLOW_DIV,
  parameter int RESET_HOLD_CYCLES = DEFAULT_RESET_HOLD_CYCLES
) (
  input  logic        clock_100mhz,
  input  logic        reset_button,
  input  logic        frequency_mode_button,
  input  logic        clock_mode_button,
  input  logic        manual_clock_button,
  input  logic        stall_core,
  output logic        core_clock_enable,
  output logic        core_reset,
  output logic        manual_mode,
  output logic        slow_mode,
  output logic [31:0] cycle_count
);

  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);

  logic [2:0] btn_raw, btn_press, btn_level_unused;
  logic       freq_press, mode_press, step_press;

  assign btn_raw    = {frequency_mode_button, clock_mode_button, manual_clock_button};
  assign freq_press = btn_press[2];
  assign mode_press = btn_press[1];
  assign step_press = btn_press[0];

  for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock_100mhz(clock_100mhz),
      .reset_button(reset_button),
      .button_i    (btn_raw[gi]),
      .level_o     (btn_level_unused[gi]),
      .press_o     (btn_press[gi])
    );
  end

  logic [1:0]       rst_sync_q;
  seq_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DIV_W-1:0] div_q, div_d, div_limit;
  logic             enable_q, enable_d;
  logic             core_reset_q, core_reset_d;
  logic             manual_q, manual_d;
  logic             slow_q, slow_d;
  logic [31:0]      count_q, count_d;

  assign div_limit = slow_q ? DIV_W'(SLOW_DIV - 1) : DIV_W'(FAST_DIV - 1);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    div_d    = '0;
    enable_d = 1'b0;
    slow_d   = slow_q;
    case (state_q)
      HOLD: begin
        if (rst_sync_q[1]) begin
          if (hold_q == HOLD_W'(RESET_HOLD_CYCLES - 1)) begin
            state_d = HALTED;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      HALTED: begin
        // Step has priority; a coincident mode press is dropped.
        if (step_press) begin
          state_d  = STEP;
          enable_d = 1'b1;
        end else if (mode_press && !stall_core) begin
          state_d = RUN;
        end
      end
      STEP: state_d = HALTED;
      RUN: begin
        if (stall_core || mode_press) begin
          state_d = HALTED;
        end else if (freq_press) begin
          div_d = '0;
        end else if (div_q == div_limit) begin
          enable_d = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = HOLD;
    endcase
    if (freq_press && (state_q != HOLD)) begin
      slow_d = ~slow_q;
    end
    manual_d     = (state_d != RUN);
    core_reset_d = (state_d == HOLD);
    count_d      = count_q + {31'd0, enable_d};
  end

  always_ff @(posedge clock_100mhz or negedge reset_button) begin
    if (!reset_button) begin
      rst_sync_q   <= 2'b00;
      state_q      <= HOLD;
      hold_q       <= '0;
      div_q        <= '0;
      enable_q     <= 1'b0;
      core_reset_q <= 1'b1;
      manual_q     <= 1'b1;
      slow_q       <= 1'b1;
      count_q      <= '0;
    end else begin
      rst_sync_q   <= {rst_sync_q[0], 1'b1};
      state_q      <= state_d;
      hold_q       <= hold_d;
      div_q        <= div_d;
      enable_q     <= enable_d;
      core_reset_q <= core_reset_d;
      manual_q     <= manual_d;
      slow_q       <= slow_d;
      count_q      <= count_d;
    end
  end

  assign core_clock_enable = enable_q;
  assign core_reset        = core_reset_q;
  assign manual_mode       = manual_q;
  assign slow_mode         = slow_q;
  assign cycle_count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_step_sequencer.sv
// ============================================================================
// Module      : tb_clock_step_sequencer
// Description : Directed bench; expected enables are queued when buttons are
//               driven and matched against each observed enable pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_step_sequencer;

  logic        clock_100mhz          = 1'b0;
  logic        reset_button          = 1'b0;
  logic        frequency_mode_button = 1'b1;
  logic        clock_mode_button     = 1'b1;
  logic        manual_clock_button   = 1'b1;
  logic        stall_core            = 1'b0;
  logic        core_clock_enable;
  logic        core_reset;
  logic        manual_mode;
  logic        slow_mode;
  logic [31:0] cycle_count;

  typedef struct {
    int          cyc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          cyc     = 0;
  int          checks  = 0;
  int          errors  = 0;
  int          c       = 0;
  logic [31:0] exp_cnt = 32'd0;

  clock_step_sequencer #(
    .DEBOUNCE_CYCLES  (4),
    .FAST_DIV         (2),
    .SLOW_DIV         (8),
    .RESET_HOLD_CYCLES(4)
  ) dut (
    .clock_100mhz         (clock_100mhz),
    .reset_button         (reset_button),
    .frequency_mode_button(frequency_mode_button),
    .clock_mode_button    (clock_mode_button),
    .manual_clock_button  (manual_clock_button),
    .stall_core           (stall_core),
    .core_clock_enable    (core_clock_enable),
    .core_reset           (core_reset),
    .manual_mode          (manual_mode),
    .slow_mode            (slow_mode),
    .cycle_count          (cycle_count)
  );

  initial forever #5 clock_100mhz = ~clock_100mhz;

  always @(posedge clock_100mhz) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock_100mhz);
  endtask

  // Queue an enable expected `offset` posedges from now.
  task automatic expect_enable(input int offset);
    exp_t e;
    exp_cnt = exp_cnt + 32'd1;
    e.cyc   = cyc + offset;
    e.cnt   = exp_cnt;
    sb.push_back(e);
  endtask

  always @(negedge clock_100mhz) begin
    exp_t e;
    if (core_clock_enable === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_enable", {31'd0, core_clock_enable}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("enable_cycle", cyc, e.cyc);
        check("enable_count", cycle_count, e.cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    wait_cyc(3);
    check("rst_enable", {31'd0, core_clock_enable}, 32'd0);
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_manual", {31'd0, manual_mode}, 32'd1);
    check("rst_slow", {31'd0, slow_mode}, 32'd1);
    check("rst_count", cycle_count, 32'd0);

    // Reset release: 2 sync edges, then 4 hold edges
    reset_button = 1'b1;
    wait_cyc(5);
    check("hold_core_reset_hi", {31'd0, core_reset}, 32'd1);
    wait_cyc(1);
    check("hold_core_reset_lo", {31'd0, core_reset}, 32'd0);
    check("post_rst_manual", {31'd0, manual_mode}, 32'd1);
    check("post_rst_slow", {31'd0, slow_mode}, 32'd1);
    check("post_rst_count", cycle_count, 32'd0);

    // Debounce: 3-cycle glitch rejected
    wait_cyc(5);
    manual_clock_button = 1'b0;
    wait_cyc(3);
    manual_clock_button = 1'b1;
    wait_cyc(20);
    check("glitch_count", cycle_count, 32'd0);

    // Debounce: 10-cycle press gives one step 8 cycles later
    manual_clock_button = 1'b0;
    expect_enable(8);
    wait_cyc(10);
    manual_clock_button = 1'b1;
    wait_cyc(20);
    check("step_pending", sb.size(), 32'd0);
    check("step_count", cycle_count, 32'd1);

    // Run slow, then switch to fast
    c = cyc;
    clock_mode_button = 1'b0;
    expect_enable(16);
    expect_enable(24);
    expect_enable(32);
    wait_cyc(10);
    clock_mode_button = 1'b1;
    wait_cyc(10);
    check("run_manual", {31'd0, manual_mode}, 32'd0);
    check("run_slow", {31'd0, slow_mode}, 32'd1);
    wait_cyc(6);
    frequency_mode_button = 1'b0;
    for (int k = 0; k < 6; k++) expect_enable(10 + 2 * k);
    wait_cyc(10);
    frequency_mode_button = 1'b1;
    wait_cyc(3);
    clock_mode_button = 1'b0;
    wait_cyc(1);
    check("fast_slow", {31'd0, slow_mode}, 32'd0);
    wait_cyc(9);
    clock_mode_button = 1'b1;
    wait_cyc(30);
    check("run_pending", sb.size(), 32'd0);
    check("run_count", cycle_count, 32'd10);
    check("halt_manual", {31'd0, manual_mode}, 32'd1);

    // Stall in RUN
    clock_mode_button = 1'b0;
    expect_enable(10);
    expect_enable(12);
    wait_cyc(10);
    clock_mode_button = 1'b1;
    wait_cyc(3);
    stall_core = 1'b1;
    wait_cyc(1);
    check("stall_manual", {31'd0, manual_mode}, 32'd1);
    check("stall_enable", {31'd0, core_clock_enable}, 32'd0);
    wait_cyc(6);
    clock_mode_button = 1'b0;
    wait_cyc(10);
    clock_mode_button = 1'b1;
    wait_cyc(20);
    check("stall_mode_manual", {31'd0, manual_mode}, 32'd1);
    check("stall_count", cycle_count, 32'd12);
    stall_core = 1'b0;
    wait_cyc(10);
    check("stall_pending", sb.size(), 32'd0);

    // Simultaneous mode + step in HALTED
    clock_mode_button   = 1'b0;
    manual_clock_button = 1'b0;
    expect_enable(8);
    wait_cyc(10);
    clock_mode_button   = 1'b1;
    manual_clock_button = 1'b1;
    wait_cyc(30);
    check("simul_manual", {31'd0, manual_mode}, 32'd1);
    check("simul_count", cycle_count, 32'd13);
    check("simul_pending", sb.size(), 32'd0);

    // Async reset between RUN enables
    clock_mode_button = 1'b0;
    expect_enable(10);
    expect_enable(12);
    wait_cyc(10);
    clock_mode_button = 1'b1;
    wait_cyc(3);
    reset_button = 1'b0;
    #1;
    check("arst_enable", {31'd0, core_clock_enable}, 32'd0);
    check("arst_core_reset", {31'd0, core_reset}, 32'd1);
    check("arst_manual", {31'd0, manual_mode}, 32'd1);
    check("arst_slow", {31'd0, slow_mode}, 32'd1);
    check("arst_count", cycle_count, 32'd0);
    exp_cnt = 32'd0;
    wait_cyc(5);
    check("arst_hold_enable", {31'd0, core_clock_enable}, 32'd0);
    check("arst_pending", sb.size(), 32'd0);
    reset_button = 1'b1;
    wait_cyc(10);
    check("arst_release", {31'd0, core_reset}, 32'd0);

    // Counter wrap
    force dut.count_q = 32'hFFFF_FFFF;
    wait_cyc(2);
    release dut.count_q;
    wait_cyc(1);
    check("wrap_preload", cycle_count, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    manual_clock_button = 1'b0;
    expect_enable(8);
    wait_cyc(10);
    manual_clock_button = 1'b1;
    wait_cyc(20);
    check("wrap_count", cycle_count, 32'd0);
    check("wrap_pending", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clock_step_sequencer.md
# clock_step_sequencer

Sequences the core clock for the FPGA core: it debounces the front-panel buttons and runs a run/halt/single-step state machine. The core is clocked directly by clock_100mhz and advances only on core_clock_enable pulses; the block replaces gated-clock generation with a one-cycle enable. It also supplies a synchronized core reset and a retired-cycle counter for the debug display.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: stable-level cycles before a button change is accepted (10 ms).
- FAST_DIV, 2: enable period in cycles, fast run mode; legal range ≥1.
- SLOW_DIV, 10_000_000: enable period in cycles, slow run mode (10 Hz); legal range ≥1.
- RESET_HOLD_CYCLES, 16: cycles core_reset stays high after reset release.
- clock_100mhz  in  1  system clock.
- reset_button  in  1  reset, asynchronous, active-low.
- frequency_mode_button  in  1  raw, active-low; each press toggles slow_mode.
- clock_mode_button  in  1  raw, active-low; each press toggles run/halt.
- manual_clock_button  in  1  raw, active-low; each press issues one step while halted.
- stall_core  in  1  level, synchronous; core breakpoint/stall request.
- core_clock_enable  out  1  one-cycle advance pulse to the core.
- core_reset  out  1  synchronous active-high core reset.
- manual_mode  out  1  1 = halted/stepping, 0 = running.
- slow_mode  out  1  1 = SLOW_DIV, 0 = FAST_DIV.
- cycle_count  out  32  number of core_clock_enable pulses since reset.

## Operation
- Reset values (reset_button low): core_clock_enable 0, core_reset 1, manual_mode 1, slow_mode 1, cycle_count 0, FSM in HOLD, divider 0, all debouncer levels at "released" (1).
- Debouncers: each button passes through a 2-flop synchronizer, then a stable-counter.
  - The level is accepted after DEBOUNCE_CYCLES consecutive equal samples.
  - An accepted 1→0 transition produces a one-cycle press pulse; release produces no pulse.
- FSM states:
  - HOLD:
    - core_reset = 1.
    - The counter runs RESET_HOLD_CYCLES after reset_button rises, then goes to HALTED.
    - Presses are ignored.
  - HALTED:
    - manual_mode = 1.
    - Step press → STEP.
    - Mode press with stall_core = 0 → RUN.
    - Mode press with stall_core = 1 is ignored.
  - STEP:
    - Asserts core_clock_enable for exactly one cycle, then → HALTED.
    - Step presses arriving in STEP are dropped.
  - RUN:
    - manual_mode = 0.
    - The divider counts 0..DIV-1, and core_clock_enable pulses when the divider equals DIV-1.
    - Mode press or stall_core = 1 → HALTED on the next edge; no enable is issued in that cycle.
- Simultaneous events:
  - stall_core beats a mode press; the result is HALTED.
  - A mode press and a step press in the same cycle in HALTED: the step wins, and the mode press is dropped.
- Frequency press: toggles slow_mode in any state except HOLD and clears the divider to 0.
- cycle_count increments on every core_clock_enable and wraps 0xFFFF_FFFF → 0.
- Asynchronous reset mid-run: everything returns to reset values immediately, and any in-flight enable is suppressed.

## Timing
- Button latency from raw edge to press pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- The press pulse is registered by the FSM on the following edge. Step pulse latency: press pulse → core_clock_enable high 1 cycle later.
- RUN entry: the first enable fires DIV cycles after the state register reads RUN. The steady period is exactly DIV cycles.
- FAST_DIV = 1: core_clock_enable stays high every cycle in RUN.
- Stall: stall_core sampled high → manual_mode = 1 and enable = 0 from the next cycle.
- core_reset deasserts on the edge RESET_HOLD_CYCLES cycles after the synchronized reset release. reset_button release is synchronized with a 2-flop synchronizer before use.
- All outputs are registered.

## Structure
- Shared package/header clock_seq_defs holds:
  - the FSM state encodings HOLD = 2'd0, HALTED = 2'd1, STEP = 2'd2, RUN = 2'd3;
  - the default parameter constants;
  - the divider width, defined as clog2(SLOW_DIV).
- Sub-module button_debouncer is instanced ×3. It has a DEBOUNCE_CYCLES parameter, inputs clock, reset and raw button, and outputs level and press pulse.
- Top level contains the reset synchronizer, FSM, divider, slow_mode toggle and cycle counter.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, FAST_DIV = 2, SLOW_DIV = 8, RESET_HOLD_CYCLES = 4.
- Reset release:
  - core_reset is high for 4 cycles after the synchronized release, then 0.
  - manual_mode = 1, slow_mode = 1, cycle_count = 0.
- Debounce:
  - A 3-cycle low glitch on manual_clock_button produces no enable.
  - A 10-cycle low pulse produces exactly one enable, 8 cycles after the falling edge, and cycle_count = 1.
- Run, slow then fast:
  - A mode press puts the block in RUN, and enables arrive every 8 cycles.
  - A frequency press sets slow_mode = 0, after which enables arrive every 2 cycles.
  - After 10 enables, cycle_count = 10.
- Stall:
  - With stall_core asserted in RUN, manual_mode = 1 the next cycle and no further enables are issued.
  - A mode press while stall_core = 1 keeps the block halted.
- Simultaneous press: mode and step pulses in the same HALTED cycle → one enable, and the state stays HALTED.
- Async reset mid-RUN: reset_button is pulled low between enables → all outputs return to reset values immediately, with no enable glitch.
- Wrap: cycle_count is forced to 0xFFFF_FFFF, then one step → cycle_count = 0.
